// File: rtl/simon_game_controller_if.sv
// Handshake bundle between the game sequencer and the WAIT_STATE input-capture block.
interface simon_game_controller_if;
    logic        wait_complete;
    logic [31:0] wait_sequence;
    logic        wait_en;
    logic        wait_clr;
    logic [3:0]  sequence_len;

    modport master (
        input  wait_complete,
        input  wait_sequence,
        output wait_en,
        output wait_clr,
        output sequence_len
    );

    modport slave (
        output wait_complete,
        output wait_sequence,
        input  wait_en,
        input  wait_clr,
        input  sequence_len
    );
endinterface

// File: rtl/simon_game_controller.sv
// Colour-memory game sequencer: builds a random 16-slot target, replays a growing
// prefix on the LEDs, arms WAIT_STATE for the reply and grades it.
//
// state    | meaning
// IDLE     | after reset, waiting for start
// GEN      | 16 cycles filling target slots from the LFSR
// SHOW_ON  | colour idx lit for SHOW_CYCLES
// SHOW_OFF | dark gap for GAP_CYCLES
// ARM      | one-cycle clear pulse to WAIT_STATE
// WAIT     | WAIT_STATE enabled, collecting the reply
// CHECK    | compare masked reply with target
// WIN      | final level passed
// LOSE     | wrong reply or timeout
module simon_game_controller #(
    parameter int unsigned MAX_LEN        = 15,
    parameter int unsigned SHOW_CYCLES    = 8,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    simon_game_controller_if.master        wait_if,
    output logic                           led_valid_o,
    output logic [1:0]                     led_colour_o,
    output logic [3:0]                     level_o,
    output logic                           game_win_o,
    output logic                           game_over_o,
    output logic [3:0]                     state_dbg_o
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        GEN      = 4'd1,
        SHOW_ON  = 4'd2,
        SHOW_OFF = 4'd3,
        ARM      = 4'd4,
        WAIT     = 4'd5,
        CHECK    = 4'd6,
        WIN      = 4'd7,
        LOSE     = 4'd8
    } state_e;

    localparam logic [15:0] SHOW_LOAD = 16'(SHOW_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LEVEL_TOP = 4'(MAX_LEN);

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [31:0] target_q, target_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  level_q, level_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] mask;

    logic        wait_en_q, wait_clr_q, led_valid_q, game_win_q, game_over_q;
    logic [3:0]  seq_len_q;
    logic [1:0]  led_colour_q;

    // Galois form, taps x^16+x^14+x^13+x^11+1
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400);
    assign mask   = (32'd1 << {level_q, 1'b0}) - 32'd1;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        idx_d      = idx_q;
        level_d    = level_q;
        timer_d    = timer_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE, WIN, LOSE: begin
                if (start_i) begin
                    state_d = GEN;
                    idx_d   = 4'd0;
                end
            end
            GEN: begin
                target_d[{idx_q, 1'b0} +: 2] = lfsr_q[1:0];
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    level_d = 4'd1;
                    idx_d   = 4'd0;
                    timer_d = SHOW_LOAD;
                    state_d = SHOW_ON;
                end
            end
            SHOW_ON: begin
                if (timer_q == 16'd0) begin
                    timer_d = GAP_LOAD;
                    state_d = SHOW_OFF;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            SHOW_OFF: begin
                if (timer_q != 16'd0) begin
                    timer_d = timer_q - 16'd1;
                end else if (idx_q == level_q - 4'd1) begin
                    state_d = ARM;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    timer_d = SHOW_LOAD;
                    state_d = SHOW_ON;
                end
            end
            ARM: begin
                wait_cnt_d = 16'd0;
                state_d    = WAIT;
            end
            WAIT: begin
                // a completion on the expiry cycle still gets graded
                if (wait_if.wait_complete) begin
                    state_d = CHECK;
                end else if (TIMEOUT_CYCLES != 0 && wait_cnt_q == TO_LAST) begin
                    state_d = LOSE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            CHECK: begin
                if (((wait_if.wait_sequence ^ target_q) & mask) != 32'd0) begin
                    state_d = LOSE;
                end else if (level_q == LEVEL_TOP) begin
                    state_d = WIN;
                end else begin
                    level_d = level_q + 4'd1;
                    idx_d   = 4'd0;
                    timer_d = SHOW_LOAD;
                    state_d = SHOW_ON;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            lfsr_q       <= LFSR_SEED;
            target_q     <= '0;
            idx_q        <= '0;
            level_q      <= '0;
            timer_q      <= '0;
            wait_cnt_q   <= '0;
            wait_en_q    <= 1'b0;
            wait_clr_q   <= 1'b0;
            seq_len_q    <= '0;
            led_valid_q  <= 1'b0;
            led_colour_q <= '0;
            game_win_q   <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            target_q     <= target_d;
            idx_q        <= idx_d;
            level_q      <= level_d;
            timer_q      <= timer_d;
            wait_cnt_q   <= wait_cnt_d;
            // outputs track the state being entered so they change on that edge
            wait_en_q    <= (state_d == WAIT);
            wait_clr_q   <= (state_d == ARM);
            if (state_d == ARM) begin
                seq_len_q <= level_q;
            end
            led_valid_q  <= (state_d == SHOW_ON);
            led_colour_q <= (state_d == SHOW_ON) ? target_q[{idx_d, 1'b0} +: 2] : 2'b00;
            game_win_q   <= (state_d == WIN);
            game_over_q  <= (state_d == LOSE);
        end
    end

    assign wait_if.wait_en      = wait_en_q;
    assign wait_if.wait_clr     = wait_clr_q;
    assign wait_if.sequence_len = seq_len_q;
    assign led_valid_o          = led_valid_q;
    assign led_colour_o         = led_colour_q;
    assign level_o              = level_q;
    assign game_win_o           = game_win_q;
    assign game_over_o          = game_over_q;
    assign state_dbg_o          = state_q;

endmodule

// File: tb/tb_simon_game_controller.sv
// Directed bench for the game sequencer, built with short show/gap times, MAX_LEN=2
// and a 20-cycle reply timeout so every scenario fits in a few hundred cycles.
module tb_simon_game_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        led_valid;
    logic [1:0]  led_colour;
    logic [3:0]  level;
    logic        game_win;
    logic        game_over;
    logic [3:0]  state_dbg;
    logic [15:0] lfsr_m;
    logic [31:0] tgt;
    logic [18:0] all_outs;
    int          checks = 0;
    int          errors = 0;

    simon_game_controller_if wif();

    simon_game_controller #(
        .MAX_LEN       (2),
        .SHOW_CYCLES   (2),
        .GAP_CYCLES    (1),
        .TIMEOUT_CYCLES(20),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .wait_if     (wif.master),
        .led_valid_o (led_valid),
        .led_colour_o(led_colour),
        .level_o     (level),
        .game_win_o  (game_win),
        .game_over_o (game_over),
        .state_dbg_o (state_dbg)
    );

    always #5 clk = ~clk;

    assign all_outs = {led_valid, led_colour, level, game_win, game_over, state_dbg,
                       wif.wait_en, wif.wait_clr, wif.sequence_len};

    // reference LFSR, x^16+x^14+x^13+x^11+1 in right-shifting Galois form
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 16'hACE1;
        else        lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        wif.wait_complete = 1'b0;
        wif.wait_sequence = 32'h0;
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            @(negedge clk);
            checks++;
            if (all_outs !== 19'h0) begin
                errors++;
                $display("FAIL reset_outs: got %h want 0", all_outs);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (state_dbg !== 4'd0 || level !== 4'd0) begin
            errors++;
            $display("FAIL idle_hold: state %0d level %0d want 0 0", state_dbg, level);
        end
    endtask

    task automatic start_game();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (state_dbg !== 4'd1 || game_win !== 1'b0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL start_gen: state %0d win %b over %b want 1 0 0", state_dbg, game_win, game_over);
        end
        for (int k = 0; k < 16; k++) begin
            tgt[2*k +: 2] = lfsr_m[1:0];
            @(negedge clk);
        end
    endtask

    task automatic show_and_arm(input int lvl);
        checks++;
        if (state_dbg !== 4'd2 || level !== 4'(lvl)) begin
            errors++;
            $display("FAIL show_entry: state %0d level %0d want 2 %0d", state_dbg, level, lvl);
        end
        for (int s = 0; s < lvl; s++) begin
            for (int r = 0; r < 2; r++) begin
                checks++;
                if (led_valid !== 1'b1 || led_colour !== tgt[2*s +: 2]) begin
                    errors++;
                    $display("FAIL show_colour slot %0d: valid %b colour %0d want 1 %0d",
                             s, led_valid, led_colour, tgt[2*s +: 2]);
                end
                @(negedge clk);
            end
            checks++;
            if (led_valid !== 1'b0 || led_colour !== 2'd0 || state_dbg !== 4'd3) begin
                errors++;
                $display("FAIL show_gap: valid %b colour %0d state %0d want 0 0 3", led_valid, led_colour, state_dbg);
            end
            @(negedge clk);
        end
        checks++;
        if (wif.wait_clr !== 1'b1 || wif.wait_en !== 1'b0 || wif.sequence_len !== 4'(lvl) || state_dbg !== 4'd4) begin
            errors++;
            $display("FAIL arm: clr %b en %b len %0d state %0d want 1 0 %0d 4",
                     wif.wait_clr, wif.wait_en, wif.sequence_len, state_dbg, lvl);
        end
        @(negedge clk);
        checks++;
        if (wif.wait_en !== 1'b1 || wif.wait_clr !== 1'b0 || state_dbg !== 4'd5) begin
            errors++;
            $display("FAIL wait_entry: en %b clr %b state %0d want 1 0 5", wif.wait_en, wif.wait_clr, state_dbg);
        end
    endtask

    task automatic reply(input logic [31:0] seq);
        wif.wait_sequence = seq;
        wif.wait_complete = 1'b1;
        @(negedge clk);
        wif.wait_complete = 1'b0;
        checks++;
        if (state_dbg !== 4'd6 || wif.wait_en !== 1'b0) begin
            errors++;
            $display("FAIL check_entry: state %0d en %b want 6 0", state_dbg, wif.wait_en);
        end
        @(negedge clk);
    endtask

    task automatic test_round_and_win();
        start_game();
        show_and_arm(1);
        reply(tgt);
        show_and_arm(2);
        reply(tgt);
        checks++;
        if (state_dbg !== 4'd7 || game_win !== 1'b1 || level !== 4'd2 || wif.wait_en !== 1'b0) begin
            errors++;
            $display("FAIL win: state %0d win %b level %0d en %b want 7 1 2 0", state_dbg, game_win, level, wif.wait_en);
        end
        for (int i = 0; i < 3; i++) begin
            wif.wait_complete = 1'b1;
            @(negedge clk);
            wif.wait_complete = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (state_dbg !== 4'd7 || game_win !== 1'b1 || level !== 4'd2) begin
            errors++;
            $display("FAIL win_hold: state %0d win %b level %0d want 7 1 2", state_dbg, game_win, level);
        end
    endtask

    task automatic test_masked_reply();
        start_game();
        show_and_arm(1);
        reply(tgt ^ 32'hC);
        show_and_arm(2);
        reply(tgt ^ 32'h4);
        checks++;
        if (state_dbg !== 4'd8 || game_over !== 1'b1 || level !== 4'd2) begin
            errors++;
            $display("FAIL mask_level2_lose: state %0d over %b level %0d want 8 1 2", state_dbg, game_over, level);
        end
    endtask

    task automatic test_wrong_reply();
        start_game();
        show_and_arm(1);
        reply(tgt ^ 32'h1);
        checks++;
        if (state_dbg !== 4'd8 || game_over !== 1'b1 || level !== 4'd1 || wif.wait_en !== 1'b0) begin
            errors++;
            $display("FAIL wrong_lose: state %0d over %b level %0d en %b want 8 1 1 0", state_dbg, game_over, level, wif.wait_en);
        end
    endtask

    task automatic test_timeout();
        start_game();
        show_and_arm(1);
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (state_dbg !== 4'd5 || game_over !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early cycle %0d: state %0d over %b want 5 0", k, state_dbg, game_over);
            end
        end
        @(negedge clk);
        checks++;
        if (state_dbg !== 4'd8 || game_over !== 1'b1 || wif.wait_en !== 1'b0 || level !== 4'd1) begin
            errors++;
            $display("FAIL timeout_lose: state %0d over %b en %b level %0d want 8 1 0 1", state_dbg, game_over, wif.wait_en, level);
        end
    endtask

    task automatic test_complete_on_expiry();
        start_game();
        show_and_arm(1);
        repeat (19) @(negedge clk);
        reply(tgt);
        checks++;
        if (state_dbg !== 4'd2 || level !== 4'd2 || game_over !== 1'b0 || led_valid !== 1'b1) begin
            errors++;
            $display("FAIL expiry_complete: state %0d level %0d over %b valid %b want 2 2 0 1", state_dbg, level, game_over, led_valid);
        end
    endtask

    task automatic test_mid_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== 19'h0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0", all_outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (state_dbg !== 4'd0 || led_valid !== 1'b0 || level !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_idle: state %0d valid %b level %0d want 0 0 0", state_dbg, led_valid, level);
        end
    endtask

    initial begin
        test_reset();
        test_round_and_win();
        test_masked_reply();
        test_wrong_reply();
        test_timeout();
        test_complete_on_expiry();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
